// File: rtl/log_line_formatter.sv
// log_line_formatter: streams one log FIFO entry (timestamp + signal bits) to
// the UART transmitter as an ASCII line "TS: 0x<hex>, S: <bits><EOL>", one byte
// per tx_ready/tx_enable handshake, with optional leading-zero suppression.
module log_line_formatter #(
   parameter int TS_WIDTH  = 30,
   parameter int SIG_WIDTH = 2,
   parameter int EOL_CRLF  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          line_trans_en,
   input  logic [TS_WIDTH+SIG_WIDTH-1:0] read_data,
   input  logic                          zero_suppress,
   input  logic                          tx_ready,
   output logic                          tx_enable,
   output logic [7:0]                    log_output,
   output logic                          line_transmitted
);

   localparam int ND   = (TS_WIDTH + 3) / 4;        // hex digits
   localparam int TSP  = ND * 4;                    // nibble-padded timestamp width
   localparam int DW   = $clog2(ND + 1);            // digit counter width
   localparam int HEX0 = 6;                         // first hex position in full layout
   localparam int MID0 = HEX0 + ND;                 // ", S: "
   localparam int SIG0 = MID0 + 5;                  // signal bits
   localparam int EOL0 = SIG0 + SIG_WIDTH;          // line ending
   localparam int LEN  = EOL0 + ((EOL_CRLF != 0) ? 2 : 1);
   localparam int PW   = $clog2(LEN);               // byte index width

   typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_SEND, ST_WAIT} state_t;

   state_t            state_q;
   logic [TSP-1:0]    ts_q;
   logic [SIG_WIDTH-1:0] sig_q;
   logic              zs_q;
   logic [DW-1:0]     ndig_q;
   logic [PW-1:0]     idx_q;
   logic [7:0]        byte_q;
   logic              line_q;

   logic [DW-1:0]     skip_c;
   logic [PW-1:0]     pos_c;
   logic [PW-1:0]     moff_c;
   logic [3:0]        nib_c;
   logic [7:0]        byte_d;
   logic              in_hex_c;
   logic              in_sig_c;
   logic              last_c;

   // Map the sent-byte index onto the full-width layout: after the fixed
   // prefix, skipped digits are added back so later sections sit at fixed
   // positions regardless of how many digits were suppressed.
   always_comb begin
      skip_c   = DW'(ND) - ndig_q;
      pos_c    = (idx_q < PW'(HEX0)) ? idx_q : (idx_q + PW'(skip_c));
      moff_c   = pos_c - PW'(MID0);
      nib_c    = ts_q[TSP-1 -: 4];
      in_hex_c = (pos_c >= PW'(HEX0)) && (pos_c < PW'(MID0));
      in_sig_c = (pos_c >= PW'(SIG0)) && (pos_c < PW'(EOL0));
      last_c   = (pos_c == PW'(LEN - 1));
      byte_d   = 8'd0;
      if (pos_c < PW'(HEX0)) begin
         case (pos_c)
            PW'(0):  byte_d = "T";
            PW'(1):  byte_d = "S";
            PW'(2):  byte_d = ":";
            PW'(3):  byte_d = " ";
            PW'(4):  byte_d = "0";
            PW'(5):  byte_d = "x";
            default: byte_d = 8'd0;
         endcase
      end else if (in_hex_c) begin
         byte_d = (nib_c < 4'd10) ? {4'h3, nib_c} : (8'd55 + {4'h0, nib_c});
      end else if (pos_c < PW'(SIG0)) begin
         case (moff_c)
            PW'(0):  byte_d = ",";
            PW'(1):  byte_d = " ";
            PW'(2):  byte_d = "S";
            PW'(3):  byte_d = ":";
            PW'(4):  byte_d = " ";
            default: byte_d = 8'd0;
         endcase
      end else if (in_sig_c) begin
         byte_d = sig_q[SIG_WIDTH-1] ? "1" : "0";
      end else begin
         byte_d = ((EOL_CRLF != 0) && (pos_c == PW'(EOL0))) ? 8'd13 : 8'd10;
      end
   end

   // Line sequencer: latch entry, skip leading zeros, then one byte per handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ts_q    <= '0;
         sig_q   <= '0;
         zs_q    <= 1'b0;
         ndig_q  <= '0;
         idx_q   <= '0;
         byte_q  <= '0;
         line_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (line_trans_en) begin
                  ts_q    <= TSP'(read_data[TS_WIDTH+SIG_WIDTH-1:SIG_WIDTH]);
                  sig_q   <= read_data[SIG_WIDTH-1:0];
                  zs_q    <= zero_suppress;
                  ndig_q  <= DW'(ND);
                  idx_q   <= '0;
                  line_q  <= 1'b0;
                  state_q <= ST_SKIP;
               end
            end
            ST_SKIP: begin
               if (zs_q && (ts_q[TSP-1 -: 4] == 4'd0) && (ndig_q > DW'(1))) begin
                  ts_q   <= ts_q << 4;
                  ndig_q <= ndig_q - 1'b1;
               end else begin
                  state_q <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_ready) begin
                  byte_q <= byte_d;
                  if (in_hex_c) ts_q  <= ts_q << 4;
                  if (in_sig_c) sig_q <= sig_q << 1;
                  if (last_c) begin
                     line_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!tx_ready) state_q <= ST_SEND;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Strobe and byte appear in the SEND cycle itself; between strobes the
   // output holds the last byte sent.
   always_comb begin
      tx_enable        = (state_q == ST_SEND) && tx_ready;
      log_output       = tx_enable ? byte_d : byte_q;
      line_transmitted = line_q;
   end

endmodule

// File: tb/tb_log_line_formatter.sv
// Self-checking bench for log_line_formatter: two parameterisations, UART
// ready/strobe models capturing bytes, expected lines queued as constants.
module tb_log_line_formatter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // DUT 1: default parameters
   logic        en1, zs1, rdy1, txe1, lt1;
   logic [31:0] rd1;
   logic [7:0]  lo1;
   // DUT 2: 16-bit timestamp, 4 signals, LF only
   logic        en2, zs2, rdy2, txe2, lt2;
   logic [19:0] rd2;
   logic [7:0]  lo2;

   log_line_formatter #(.TS_WIDTH(30), .SIG_WIDTH(2), .EOL_CRLF(1)) dut1 (
      .clk(clk), .rst(rst), .line_trans_en(en1), .read_data(rd1),
      .zero_suppress(zs1), .tx_ready(rdy1), .tx_enable(txe1),
      .log_output(lo1), .line_transmitted(lt1));

   log_line_formatter #(.TS_WIDTH(16), .SIG_WIDTH(4), .EOL_CRLF(0)) dut2 (
      .clk(clk), .rst(rst), .line_trans_en(en2), .read_data(rd2),
      .zero_suppress(zs2), .tx_ready(rdy2), .tx_enable(txe2),
      .log_output(lo2), .line_transmitted(lt2));

   logic [7:0]  rx1[$], exp1[$], rx2[$], exp2[$];
   int unsigned rxt1[$], rxt2[$];
   int          hold1 = 10, cnt1 = 0, cnt2 = 0;
   bit          force1 = 1'b0;
   bit          s1, s2;
   logic [7:0]  b1, b2;
   int unsigned tacc;

   // UART model 1: capture strobes mid-cycle, drop ready after each byte
   initial begin
      rdy1 = 1'b1;
      forever begin
         @(negedge clk);
         s1 = txe1; b1 = lo1;
         if (s1) begin rx1.push_back(b1); rxt1.push_back(cyc); end
         @(posedge clk); #1;
         if (s1) cnt1 = hold1; else if (cnt1 > 0) cnt1--;
         rdy1 = (cnt1 == 0) && !force1;
      end
   end

   // UART model 2
   initial begin
      rdy2 = 1'b1;
      forever begin
         @(negedge clk);
         s2 = txe2; b2 = lo2;
         if (s2) begin rx2.push_back(b2); rxt2.push_back(cyc); end
         @(posedge clk); #1;
         if (s2) cnt2 = 3; else if (cnt2 > 0) cnt2--;
         rdy2 = (cnt2 == 0);
      end
   end

   task automatic push_exp(input int which, input string s, input bit crlf);
      for (int i = 0; i < s.len(); i++) begin
         if (which == 1) exp1.push_back(s[i]); else exp2.push_back(s[i]);
      end
      if (crlf) begin
         if (which == 1) exp1.push_back(8'd13); else exp2.push_back(8'd13);
      end
      if (which == 1) exp1.push_back(8'd10); else exp2.push_back(8'd10);
   endtask

   task automatic clear1();
      rx1.delete(); rxt1.delete(); exp1.delete();
   endtask

   task automatic start_line1(input logic [29:0] ts, input logic [1:0] sig, input logic zs);
      @(negedge clk); #2;
      rd1 = {ts, sig}; zs1 = zs; en1 = 1'b1; tacc = cyc;
      @(negedge clk); #2;
      en1 = 1'b0; rd1 = ~rd1; zs1 = ~zs;
   endtask

   task automatic wait_bytes1(input int n, input int budget, output bit ok);
      int i = 0;
      while (rx1.size() < n && i < budget) begin
         @(negedge clk); #2;
         i++;
      end
      ok = (rx1.size() >= n);
   endtask

   task automatic test_reset();
      checks++; if (txe1 !== 1'b0) begin errors++; $display("FAIL reset_txe1: got %b want 0", txe1); end
      checks++; if (lo1 !== 8'd0) begin errors++; $display("FAIL reset_lo1: got %h want 00", lo1); end
      checks++; if (lt1 !== 1'b1) begin errors++; $display("FAIL reset_lt1: got %b want 1", lt1); end
      checks++; if (txe2 !== 1'b0) begin errors++; $display("FAIL reset_txe2: got %b want 0", txe2); end
      checks++; if (lo2 !== 8'd0) begin errors++; $display("FAIL reset_lo2: got %h want 00", lo2); end
      checks++; if (lt2 !== 1'b1) begin errors++; $display("FAIL reset_lt2: got %b want 1", lt2); end
   endtask

   // Full-line check for DUT 1 including first-strobe latency
   task automatic test_line1(input string name, input logic [29:0] ts, input logic [1:0] sig,
                             input logic zs, input string txt, input int lat);
      bit ok;
      int n;
      logic [7:0] e, g;
      bit spacing_ok;
      clear1();
      push_exp(1, txt, 1'b1);
      n = exp1.size();
      start_line1(ts, sig, zs);
      wait_bytes1(n, 4000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: got %0d bytes want %0d", name, rx1.size(), n); end
      checks++; if (lt1 !== 1'b0) begin errors++; $display("FAIL %s_lt_last: got %b want 0", name, lt1); end
      @(negedge clk); #2;
      checks++; if (lt1 !== 1'b1) begin errors++; $display("FAIL %s_lt_after: got %b want 1", name, lt1); end
      checks++;
      if (rxt1.size() == 0 || rxt1[0] - tacc != lat) begin
         errors++;
         $display("FAIL %s_latency: got %0d want %0d", name, (rxt1.size() != 0) ? int'(rxt1[0] - tacc) : -1, lat);
      end
      spacing_ok = 1'b1;
      for (int i = 1; i < rxt1.size(); i++) if (rxt1[i] - rxt1[i-1] < 2) spacing_ok = 1'b0;
      checks++; if (!spacing_ok) begin errors++; $display("FAIL %s_spacing: got strobes closer than 2 cycles want >=2", name); end
      checks++; if (rx1.size() != n) begin errors++; $display("FAIL %s_count: got %0d want %0d", name, rx1.size(), n); end
      for (int i = 0; i < n; i++) begin
         e = exp1.pop_front();
         g = (rx1.size() != 0) ? rx1.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin errors++; $display("FAIL %s_byte%0d: got %h want %h", name, i, g, e); end
      end
   endtask

   task automatic test_param_variant();
      int i = 0;
      int n;
      logic [7:0] e, g;
      rx2.delete(); rxt2.delete(); exp2.delete();
      push_exp(2, "TS: 0xBEEF, S: 0110", 1'b0);
      n = exp2.size();
      @(negedge clk); #2;
      rd2 = {16'hBEEF, 4'b0110}; zs2 = 1'b0; en2 = 1'b1; tacc = cyc;
      @(negedge clk); #2;
      en2 = 1'b0; rd2 = '0;
      while (rx2.size() < n && i < 2000) begin @(negedge clk); #2; i++; end
      @(negedge clk); #2;
      checks++; if (lt2 !== 1'b1) begin errors++; $display("FAIL var_lt_after: got %b want 1", lt2); end
      checks++;
      if (rxt2.size() == 0 || rxt2[0] - tacc != 2) begin
         errors++; $display("FAIL var_latency: got %0d want 2", (rxt2.size() != 0) ? int'(rxt2[0] - tacc) : -1);
      end
      checks++; if (rx2.size() != n) begin errors++; $display("FAIL var_count: got %0d want %0d", rx2.size(), n); end
      for (int k = 0; k < n; k++) begin
         e = exp2.pop_front();
         g = (rx2.size() != 0) ? rx2.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin errors++; $display("FAIL var_byte%0d: got %h want %h", k, g, e); end
      end
   endtask

   task automatic test_ignore_mid_line();
      bit ok;
      int n;
      logic [7:0] e, g;
      clear1();
      push_exp(1, "TS: 0x00001A2F, S: 10", 1'b1);
      n = exp1.size();
      start_line1(30'h0000_1A2F, 2'b10, 1'b0);
      wait_bytes1(5, 1000, ok);
      rd1 = {30'h3ABC_DEF1, 2'b01}; zs1 = 1'b1; en1 = 1'b1;
      @(negedge clk); #2;
      en1 = 1'b0;
      wait_bytes1(n, 4000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ign_timeout: got %0d want %0d", rx1.size(), n); end
      for (int i = 0; i < n; i++) begin
         e = exp1.pop_front();
         g = (rx1.size() != 0) ? rx1.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin errors++; $display("FAIL ign_byte%0d: got %h want %h", i, g, e); end
      end
      repeat (30) @(negedge clk);
      #2;
      checks++; if (rx1.size() != 0) begin errors++; $display("FAIL ign_extra: got %0d extra bytes want 0", rx1.size()); end
      checks++; if (lt1 !== 1'b1) begin errors++; $display("FAIL ign_idle: got %b want 1", lt1); end
   endtask

   task automatic test_stall();
      bit ok;
      bit stable;
      int n;
      logic [7:0] held, e, g;
      clear1();
      push_exp(1, "TS: 0x00001A2F, S: 10", 1'b1);
      n = exp1.size();
      start_line1(30'h0000_1A2F, 2'b10, 1'b0);
      wait_bytes1(3, 1000, ok);
      force1 = 1'b1;
      held = lo1;
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk); #2;
         if (lo1 !== held || txe1 !== 1'b0) stable = 1'b0;
      end
      checks++; if (rx1.size() != 3) begin errors++; $display("FAIL stall_strobe: got %0d bytes want 3", rx1.size()); end
      checks++; if (!stable) begin errors++; $display("FAIL stall_hold: got output change want stable %h", held); end
      checks++; if (held !== 8'h3A) begin errors++; $display("FAIL stall_byte: got %h want 3a", held); end
      force1 = 1'b0;
      wait_bytes1(n, 4000, ok);
      for (int i = 0; i < n; i++) begin
         e = exp1.pop_front();
         g = (rx1.size() != 0) ? rx1.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, g, e); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear1();
      start_line1(30'h0000_1A2F, 2'b10, 1'b0);
      wait_bytes1(9, 1000, ok);
      rst = 1'b1;
      #1;
      checks++; if (txe1 !== 1'b0) begin errors++; $display("FAIL rmid_txe: got %b want 0", txe1); end
      checks++; if (lo1 !== 8'd0) begin errors++; $display("FAIL rmid_lo: got %h want 00", lo1); end
      checks++; if (lt1 !== 1'b1) begin errors++; $display("FAIL rmid_lt: got %b want 1", lt1); end
      repeat (3) @(negedge clk);
      #2;
      checks++; if (rx1.size() != 9) begin errors++; $display("FAIL rmid_abort: got %0d bytes want 9", rx1.size()); end
      rst = 1'b0;
      repeat (12) @(negedge clk);
      test_line1("rpost", 30'h0000_1A2F, 2'b10, 1'b0, "TS: 0x00001A2F, S: 10", 2);
   endtask

   task automatic test_back_to_back();
      bit ok;
      int n;
      logic [7:0] e, g;
      hold1 = 1;
      repeat (12) @(negedge clk);
      clear1();
      push_exp(1, "TS: 0x00001A2F, S: 10", 1'b1);
      push_exp(1, "TS: 0x1A2F, S: 10", 1'b1);
      n = exp1.size();
      start_line1(30'h0000_1A2F, 2'b10, 1'b0);
      wait_bytes1(23, 2000, ok);
      start_line1(30'h0000_1A2F, 2'b10, 1'b1);
      wait_bytes1(n, 2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d want %0d", rx1.size(), n); end
      checks++;
      if (rxt1.size() < 24 || rxt1[23] != rxt1[22] + 7) begin
         errors++; $display("FAIL b2b_restart: got gap %0d want 7", (rxt1.size() >= 24) ? int'(rxt1[23] - rxt1[22]) : -1);
      end
      for (int i = 0; i < n; i++) begin
         e = exp1.pop_front();
         g = (rx1.size() != 0) ? rx1.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, g, e); end
      end
      hold1 = 10;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      en1 = 1'b0; zs1 = 1'b0; rd1 = '0;
      en2 = 1'b0; zs2 = 1'b0; rd2 = '0;
      repeat (3) @(negedge clk);
      test_reset();
      #2 rst = 1'b0;
      @(negedge clk); #2;
      test_reset();
      test_line1("dflt", 30'h0000_1A2F, 2'b10, 1'b0, "TS: 0x00001A2F, S: 10", 2);
      repeat (12) @(negedge clk);
      test_line1("zs", 30'h0000_1A2F, 2'b10, 1'b1, "TS: 0x1A2F, S: 10", 6);
      repeat (12) @(negedge clk);
      test_line1("zero", 30'h0000_0000, 2'b10, 1'b1, "TS: 0x0, S: 10", 9);
      repeat (12) @(negedge clk);
      test_line1("full", 30'h3FFF_FFFF, 2'b10, 1'b1, "TS: 0x3FFFFFFF, S: 10", 2);
      repeat (12) @(negedge clk);
      test_param_variant();
      repeat (12) @(negedge clk);
      test_ignore_mid_line();
      repeat (12) @(negedge clk);
      test_stall();
      repeat (12) @(negedge clk);
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
